// File: rtl/alu_defs.sv
// Shared ALU definitions: default datapath width, add/sub mode encoding and
// flag bit positions shared with the ALU flag register.
package alu_defs;
  localparam int ALU_WIDTH = 32;
  localparam int NUM_FLAGS = 3;
  localparam int FLAG_C    = 0;
  localparam int FLAG_V    = 1;
  localparam int FLAG_Z    = 2;

  typedef enum logic {
    MODE_ADD = 1'b0,
    MODE_SUB = 1'b1
  } addsub_mode_e;

  // Operands of equal sign producing a result of the other sign overflowed.
  function automatic logic signed_overflow(input logic sign_a, input logic sign_b,
                                           input logic sign_c);
    return (sign_a == sign_b) && (sign_c != sign_a);
  endfunction
endpackage

// File: rtl/pipelined_addsub_if.sv
// Operand/result handshake bundle of the pipelined add/subtract unit.
interface pipelined_addsub_if #(
  parameter int WIDTH = alu_defs::ALU_WIDTH
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] c;
  logic             carry;
  logic             overflow;
  logic             zero;

  modport master (
    output in_valid, a, b, sub, out_ready,
    input  in_ready, out_valid, c, carry, overflow, zero
  );

  modport slave (
    input  in_valid, a, b, sub, out_ready,
    output in_ready, out_valid, c, carry, overflow, zero
  );
endinterface

// File: rtl/addsub_segment.sv
// Combinational SEG-bit adder slice with carry-in and carry-out.
module addsub_segment #(
  parameter int SEG = 16
) (
  input  logic [SEG-1:0] a_i,
  input  logic [SEG-1:0] b_i,
  input  logic           cin_i,
  output logic [SEG-1:0] sum_o,
  output logic           cout_o
);
  assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{SEG{1'b0}}, cin_i};
endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined two's-complement add/subtract: the carry chain is cut into STAGES
// segments, one register boundary each, with a global stall on output backpressure.
module pipelined_addsub
  import alu_defs::*;
#(
  parameter int WIDTH  = ALU_WIDTH,
  parameter int STAGES = 2
) (
  input logic               clk,
  input logic               rst_n,
  pipelined_addsub_if.slave bus
);
  localparam int SEG = WIDTH / STAGES;

  logic stall_s;

  assign stall_s      = bus.out_valid && !bus.out_ready;
  assign bus.in_ready = !stall_s;

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    localparam int LO  = k * SEG;      // result bits already produced upstream
    localparam int REM = WIDTH - LO;   // operand bits still to be added

    logic [REM-1:0]    a_in_s;
    logic [REM-1:0]    b_in_s;
    logic              cin_s;
    logic              vld_in_s;
    logic              sign_a_in_s;
    logic              sign_b_in_s;
    logic [SEG-1:0]    sum_s;
    logic              cout_s;
    logic [LO+SEG-1:0] res_d;
    logic              vld_q;

    if (k == 0) begin : g_src
      logic sub_s;
      // B is inverted here once so later segments only ever add
      assign sub_s       = (bus.sub == MODE_SUB);
      assign a_in_s      = bus.a;
      assign b_in_s      = bus.b ^ {WIDTH{sub_s}};
      assign cin_s       = sub_s;
      assign vld_in_s    = bus.in_valid;
      assign sign_a_in_s = bus.a[WIDTH-1];
      assign sign_b_in_s = b_in_s[REM-1];
      assign res_d       = sum_s;
    end else begin : g_src
      assign a_in_s      = g_stg[k-1].g_fwd.a_rem_q;
      assign b_in_s      = g_stg[k-1].g_fwd.b_rem_q;
      assign cin_s       = g_stg[k-1].g_fwd.carry_q;
      assign vld_in_s    = g_stg[k-1].vld_q;
      assign sign_a_in_s = g_stg[k-1].g_fwd.sign_a_q;
      assign sign_b_in_s = g_stg[k-1].g_fwd.sign_b_q;
      assign res_d       = {sum_s, g_stg[k-1].g_fwd.res_q};
    end

    addsub_segment #(.SEG(SEG)) u_seg (
      .a_i   (a_in_s[SEG-1:0]),
      .b_i   (b_in_s[SEG-1:0]),
      .cin_i (cin_s),
      .sum_o (sum_s),
      .cout_o(cout_s)
    );

    // Stage valid bit: advances unless stalled, cleared by reset
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q <= 1'b0;
      end else if (!stall_s) begin
        vld_q <= vld_in_s;
      end
    end

    if (k < STAGES - 1) begin : g_fwd
      logic [REM-SEG-1:0] a_rem_q;
      logic [REM-SEG-1:0] b_rem_q;
      logic [LO+SEG-1:0]  res_q;
      logic               carry_q;
      logic               sign_a_q;
      logic               sign_b_q;

      // Intermediate stage: partial sum, segment carry and unconsumed operands
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_rem_q  <= {(REM-SEG){1'b0}};
          b_rem_q  <= {(REM-SEG){1'b0}};
          res_q    <= {(LO+SEG){1'b0}};
          carry_q  <= 1'b0;
          sign_a_q <= 1'b0;
          sign_b_q <= 1'b0;
        end else if (!stall_s && vld_in_s) begin
          a_rem_q  <= a_in_s[REM-1:SEG];
          b_rem_q  <= b_in_s[REM-1:SEG];
          res_q    <= res_d;
          carry_q  <= cout_s;
          sign_a_q <= sign_a_in_s;
          sign_b_q <= sign_b_in_s;
        end
      end
    end

    if (k == STAGES - 1) begin : g_fin
      logic [WIDTH-1:0]     c_q;
      logic [NUM_FLAGS-1:0] flags_d;
      logic [NUM_FLAGS-1:0] flags_q;

      // Flags come from the completed sum so they register alongside c
      always_comb begin
        flags_d         = {NUM_FLAGS{1'b0}};
        flags_d[FLAG_C] = cout_s;
        flags_d[FLAG_V] = signed_overflow(sign_a_in_s, sign_b_in_s, res_d[WIDTH-1]);
        flags_d[FLAG_Z] = ~|res_d;
      end

      // Output stage: result and flags, held while the consumer stalls
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          c_q     <= {WIDTH{1'b0}};
          flags_q <= {NUM_FLAGS{1'b0}};
        end else if (!stall_s && vld_in_s) begin
          c_q     <= res_d;
          flags_q <= flags_d;
        end
      end

      assign bus.out_valid = vld_q;
      assign bus.c         = c_q;
      assign bus.carry     = flags_q[FLAG_C];
      assign bus.overflow  = flags_q[FLAG_V];
      assign bus.zero      = flags_q[FLAG_Z];
    end
  end
endmodule

// File: tb/tb_pipelined_addsub.sv
// Bench for pipelined_addsub: directed vectors, backpressured stream, reset in
// flight, and a WIDTH/STAGES sweep checked against a behavioural model.
module tb_pipelined_addsub;
  localparam int W = 32;
  localparam int S = 2;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic [W-1:0] c;
    logic         carry;
    logic         ovf;
    logic         zero;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         sweep_go;
  logic         mon_en;
  logic         stream_done;
  logic         was_stall;
  logic [W+2:0] held;
  logic [W+2:0] exp_q[$];
  vec_t         tbl[10];
  int           n_pass = 0;
  int           n_total = 0;

  always #5 clk = ~clk;

  pipelined_addsub_if #(.WIDTH(W)) m_if ();
  pipelined_addsub #(.WIDTH(W), .STAGES(S)) u_dut (.clk(clk), .rst_n(rst_n), .bus(m_if));

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    n_total++;
    $display("FAIL %s: got unexpected/timeout event, expected none", name);
  endtask

  function automatic logic [W+2:0] m_bundle();
    return {m_if.zero, m_if.overflow, m_if.carry, m_if.c};
  endfunction

  // Scoreboard and handshake monitor for the main instance
  always @(negedge clk) begin
    if (mon_en) begin
      check("in_ready_vs_stall", 72'(m_if.in_ready), 72'(!(m_if.out_valid && !m_if.out_ready)));
      if (was_stall) begin
        check("stall_hold_data", 72'(m_bundle()), 72'(held));
        check("stall_hold_valid", 72'(m_if.out_valid), 72'd1);
      end
      if (m_if.out_valid && m_if.out_ready) begin
        if (exp_q.size() == 0) fail_now("unexpected_result");
        else check("result", 72'(m_bundle()), 72'(exp_q.pop_front()));
      end
      was_stall = m_if.out_valid && !m_if.out_ready;
      held      = m_bundle();
    end else begin
      was_stall = 1'b0;
    end
  end

  // Called #1 after a rising edge; returns #1 after the edge that took the op.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                      input logic [W+2:0] exp);
    int t;
    m_if.a = a;
    m_if.b = b;
    m_if.sub = s;
    m_if.in_valid = 1'b1;
    t = 0;
    @(negedge clk);
    while (!m_if.in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (m_if.in_ready) exp_q.push_back(exp);
    else fail_now("send_timeout");
    @(posedge clk);
    #1;
    m_if.in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    check(name, 72'(exp_q.size()), 72'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int lat;
    int t;
    tbl[0] = '{32'h00000001, 32'h00000001, 1'b0, 32'h00000002, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1};
    tbl[2] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{32'h00000002, 32'h00000002, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1};
    tbl[4] = '{32'h00000000, 32'h00000001, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{32'h0000FFFF, 32'h00000001, 1'b0, 32'h00010000, 1'b0, 1'b0, 1'b0};
    tbl[6] = '{32'h80000000, 32'h00000001, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0};
    tbl[7] = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b1};
    tbl[8] = '{32'h00000005, 32'h00000007, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};
    tbl[9] = '{32'h00000000, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1};

    rst_n = 1'b0;
    sweep_go = 1'b0;
    mon_en = 1'b0;
    stream_done = 1'b0;
    was_stall = 1'b0;
    held = '0;
    m_if.in_valid = 1'b0;
    m_if.a = '0;
    m_if.b = '0;
    m_if.sub = 1'b0;
    m_if.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_out_valid", 72'(m_if.out_valid), 72'd0);
    check("reset_outputs", 72'(m_bundle()), 72'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("reset_in_ready", 72'(m_if.in_ready), 72'd1);
    mon_en = 1'b1;

    for (int i = 0; i < 10; i++) begin
      send(tbl[i].a, tbl[i].b, tbl[i].sub, {tbl[i].zero, tbl[i].ovf, tbl[i].carry, tbl[i].c});
      lat = 0;
      do begin
        @(negedge clk);
        lat++;
      end while (!m_if.out_valid && lat < 20);
      check("latency", 72'(lat), 72'(S));
      @(posedge clk);
      #1;
    end
    check("table_drained", 72'(exp_q.size()), 72'd0);

    fork
      begin
        for (int i = 0; i < 16; i++) begin
          send(W'(i), W'(2 * i), 1'b0, {1'(i == 0), 1'b0, 1'b0, W'(3 * i)});
        end
        stream_done = 1'b1;
      end
      begin
        while (!stream_done) begin
          m_if.out_ready = ($urandom_range(0, 1) == 1);
          @(posedge clk);
          #1;
        end
      end
    join
    m_if.out_ready = 1'b1;
    drain("stream_drained");

    send(32'd10, 32'd20, 1'b0, {1'b0, 1'b0, 1'b0, 32'd30});
    send(32'd40, 32'd2, 1'b1, {1'b0, 1'b0, 1'b1, 32'd38});
    #2;
    mon_en = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 72'(m_if.out_valid), 72'd0);
    check("midrst_outputs", 72'(m_bundle()), 72'd0);
    exp_q.delete();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("no_stale_after_reset", 72'(m_if.out_valid), 72'd0);
    end
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    send(32'd7, 32'd5, 1'b1, {1'b0, 1'b0, 1'b1, 32'd2});
    drain("post_reset_drained");

    sweep_go = 1'b1;
    t = 0;
    while (!(g_sw[0].done && g_sw[1].done && g_sw[2].done && g_sw[3].done) && t < 20000) begin
      @(posedge clk);
      t++;
    end
    check("sweep_complete",
          72'({g_sw[3].done, g_sw[2].done, g_sw[1].done, g_sw[0].done}), 72'hF);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  for (genvar g = 0; g < 4; g++) begin : g_sw
    localparam int SW = (g < 3) ? 8 : 64;
    localparam int SS = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 4 : 8;

    pipelined_addsub_if #(.WIDTH(SW)) s_if ();
    pipelined_addsub #(.WIDTH(SW), .STAGES(SS)) u_dut (.clk(clk), .rst_n(rst_n), .bus(s_if));

    logic [SW+2:0] q[$];
    logic          done = 1'b0;

    function automatic logic [SW+2:0] ref_model(input logic [SW-1:0] x, input logic [SW-1:0] y,
                                                input logic s);
      logic [SW:0] full;
      logic [SW:0] sext;
      logic        cy;
      logic        v;
      if (s) begin
        full = {1'b0, x} - {1'b0, y};
        cy   = ~full[SW];
        sext = {x[SW-1], x} - {y[SW-1], y};
      end else begin
        full = {1'b0, x} + {1'b0, y};
        cy   = full[SW];
        sext = {x[SW-1], x} + {y[SW-1], y};
      end
      v = sext[SW] ^ sext[SW-1];
      return {(full[SW-1:0] == {SW{1'b0}}), v, cy, full[SW-1:0]};
    endfunction

    function automatic logic [SW-1:0] rnd();
      logic [63:0] r;
      r = {$urandom, $urandom};
      return r[SW-1:0];
    endfunction

    always @(negedge clk) begin
      if (s_if.out_valid && s_if.out_ready) begin
        if (q.size() == 0) fail_now($sformatf("sweep_w%0d_s%0d_unexpected", SW, SS));
        else check($sformatf("sweep_w%0d_s%0d_result", SW, SS),
                   72'({s_if.zero, s_if.overflow, s_if.carry, s_if.c}), 72'(q.pop_front()));
      end
    end

    initial begin
      int lat;
      int n;
      int guard;
      logic took;
      s_if.in_valid = 1'b0;
      s_if.a = '0;
      s_if.b = '0;
      s_if.sub = 1'b0;
      s_if.out_ready = 1'b1;
      wait (sweep_go);
      @(posedge clk);
      #1;
      s_if.a = rnd();
      s_if.b = rnd();
      s_if.sub = 1'($urandom_range(0, 1));
      s_if.in_valid = 1'b1;
      @(negedge clk);
      check($sformatf("sweep_w%0d_s%0d_in_ready", SW, SS), 72'(s_if.in_ready), 72'd1);
      q.push_back(ref_model(s_if.a, s_if.b, s_if.sub));
      @(posedge clk);
      #1;
      s_if.in_valid = 1'b0;
      lat = 0;
      do begin
        @(negedge clk);
        lat++;
      end while (!s_if.out_valid && lat < 40);
      check($sformatf("sweep_w%0d_s%0d_latency", SW, SS), 72'(lat), 72'(SS));
      @(posedge clk);
      #1;

      s_if.a = rnd();
      s_if.b = rnd();
      s_if.sub = 1'($urandom_range(0, 1));
      s_if.in_valid = 1'b1;
      n = 0;
      guard = 0;
      while (n < 24 && guard < 1000) begin
        @(negedge clk);
        guard++;
        took = s_if.in_ready;
        if (took) begin
          q.push_back(ref_model(s_if.a, s_if.b, s_if.sub));
          n++;
        end
        @(posedge clk);
        #1;
        s_if.out_ready = ($urandom_range(0, 3) != 0);
        if (took) begin
          s_if.a = rnd();
          s_if.b = rnd();
          s_if.sub = 1'($urandom_range(0, 1));
        end
      end
      s_if.in_valid = 1'b0;
      s_if.out_ready = 1'b1;
      guard = 0;
      while (q.size() != 0 && guard < 300) begin
        @(negedge clk);
        guard++;
      end
      check($sformatf("sweep_w%0d_s%0d_drained", SW, SS), 72'(q.size()), 72'd0);
      done = 1'b1;
    end
  end
endmodule
